// File: rtl/composer_clk_pkg.sv
// Shared constants and helpers for the composer clock/strobe generator.
package composer_clk_pkg;
    localparam int CNT_W_DEFAULT    = 22;
    localparam int HALF_5MHZ        = 5;
    localparam int HALF_16HZ        = 1562500;   // needs a counter at least 21 bits wide
    localparam int DEFAULT_HALF_CYC = HALF_5MHZ;

    // Channel-select width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, single pending-divisor slot, registered tick/clk_out.
module clk_div_channel
    import composer_clk_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend_valid,
    output logic             tick,
    output logic             clk_out
);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] pend_r;
    logic             pend_valid_r;
    logic             tick_r;
    logic             clk_out_r;
    logic             idle_s;
    logic             wrap_s;

    // A disabled or muted channel is idle; otherwise it wraps at half-1.
    always_comb begin
        idle_s = 1'b0;
        wrap_s = 1'b0;
        if (!run || (half_r == ZERO)) begin
            idle_s = 1'b1;
        end else begin
            wrap_s = (count_r == (half_r - ONE));
        end
    end

    // Counter, retune and output registers share one edge so tick and clk_out stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r      <= ZERO;
            half_r       <= HALF_INIT;
            pend_r       <= ZERO;
            pend_valid_r <= 1'b0;
            tick_r       <= 1'b0;
            clk_out_r    <= 1'b0;
        end else begin
            if (idle_s) begin
                count_r   <= ZERO;
                tick_r    <= 1'b0;
                clk_out_r <= 1'b0;
                if (pend_valid_r) begin
                    half_r       <= pend_r;
                    pend_valid_r <= 1'b0;
                end
            end else if (wrap_s) begin
                count_r   <= ZERO;
                tick_r    <= 1'b1;
                clk_out_r <= ~clk_out_r;
                if (pend_valid_r) begin
                    half_r       <= pend_r;
                    pend_valid_r <= 1'b0;
                end
            end else begin
                count_r <= count_r + ONE;
                tick_r  <= 1'b0;
            end
            // Writes only land while the slot is empty, so they never collide with the clear above.
            if (wr_en) begin
                pend_r       <= wr_div;
                pend_valid_r <= 1'b1;
            end
        end
    end

    assign pend_valid = pend_valid_r;
    assign tick       = tick_r;
    assign clk_out    = clk_out_r;
endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable/square-wave generator with glitch-free runtime retuning.
module clock_divider_multi
    import composer_clk_pkg::*;
#(
    parameter int  NUM_CH       = 4,
    parameter int  CNT_W        = CNT_W_DEFAULT,
    parameter int  DEFAULT_HALF = DEFAULT_HALF_CYC,
    localparam int CH_W         = ch_width(NUM_CH)
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);
    localparam int PAD_W = 1 << CH_W;
    localparam int CMP_W = CH_W + 1;

    logic [NUM_CH-1:0] pend_valid_s;
    logic [NUM_CH-1:0] wr_en_s;
    logic [PAD_W-1:0]  pend_pad_s;
    logic              in_range_s;
    logic              ready_s;

    // Out-of-range selects always handshake and are dropped.
    always_comb begin
        pend_pad_s             = '0;
        pend_pad_s[NUM_CH-1:0] = pend_valid_s;
        in_range_s             = ({1'b0, cfg_ch} < CMP_W'(NUM_CH));
        if (in_range_s) begin
            ready_s = ~pend_pad_s[cfg_ch];
        end else begin
            ready_s = 1'b1;
        end
    end

    assign cfg_ready = ready_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_en_s[c] = cfg_valid && ready_s && (cfg_ch == CH_W'(c));

        clk_div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk        (CLOCK_50),
            .rst_n      (resetn),
            .run        (enable[c]),
            .wr_en      (wr_en_s[c]),
            .wr_div     (cfg_div),
            .pend_valid (pend_valid_s[c]),
            .tick       (tick[c]),
            .clk_out    (clk_out[c])
        );
    end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench: time-based reference model, vector table, directed corner sequences.
module tb_clock_divider_multi;
    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  enable;
    logic        cfg_valid;
    logic [1:0]  cfg_ch;
    logic [21:0] cfg_div;
    logic        cfg_ready;
    logic [3:0]  tick;
    logic [3:0]  clk_out;
    logic        cfg_ready3;
    logic [2:0]  tick3;
    logic [2:0]  clk_out3;

    always #5 clk = ~clk;

    clock_divider_multi #(.NUM_CH(4)) dut (
        .CLOCK_50 (clk), .resetn (resetn), .enable (enable), .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
        .tick (tick), .clk_out (clk_out)
    );

    clock_divider_multi #(.NUM_CH(3)) dut3 (
        .CLOCK_50 (clk), .resetn (resetn), .enable (enable[2:0]), .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready3), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
        .tick (tick3), .clk_out (clk_out3)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: each running channel owns an absolute deadline (edge index of next tick).
    int         m_half [4];
    int         m_pend [4];
    int         m_dead [4];
    bit         m_pv   [4];
    bit         m_run  [4];
    logic [3:0] m_tick;
    logic [3:0] m_clk;

    typedef struct {
        int ch;
        int div;
        int exp_first;
        int exp_gap;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_half[c] = 5;
            m_pend[c] = 0;
            m_dead[c] = 0;
            m_pv[c]   = 1'b0;
            m_run[c]  = 1'b0;
        end
        m_tick = '0;
        m_clk  = '0;
    endfunction

    // Inputs are set at a negedge; this checks ready, predicts the edge, and checks the outputs.
    task automatic step();
        bit acc;
        int ch;
        #1;
        ch = int'(cfg_ch);
        check("cfg_ready", int'(cfg_ready), int'(!m_pv[ch]));
        check("cfg_ready3", int'(cfg_ready3), (ch == 3) ? 1 : int'(!m_pv[ch]));
        acc = cfg_valid && !m_pv[ch];
        for (int c = 0; c < 4; c++) begin
            if (enable[c] && (m_half[c] != 0)) begin
                if (!m_run[c]) begin
                    m_run[c]  = 1'b1;
                    m_dead[c] = cyc + m_half[c] - 1;
                end
                m_tick[c] = (cyc == m_dead[c]);
                if (m_tick[c]) begin
                    m_clk[c] = ~m_clk[c];
                    if (m_pv[c]) begin
                        m_half[c] = m_pend[c];
                        m_pv[c]   = 1'b0;
                    end
                    m_dead[c] = cyc + m_half[c];
                end
            end else begin
                m_run[c]  = 1'b0;
                m_tick[c] = 1'b0;
                m_clk[c]  = 1'b0;
                if (m_pv[c]) begin
                    m_half[c] = m_pend[c];
                    m_pv[c]   = 1'b0;
                end
            end
        end
        if (acc) begin
            m_pend[ch] = int'(cfg_div);
            m_pv[ch]   = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("tick", int'(tick), int'(m_tick));
        check("clk_out", int'(clk_out), int'(m_clk));
        check("tick3", int'(tick3), int'(m_tick[2:0]));
        check("clk_out3", int'(clk_out3), int'(m_clk[2:0]));
        if (acc) cfg_valid = 1'b0;
    endtask

    // Steps until tick[ch] is seen; n = steps taken, 0 if the budget expired.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tick[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{0, 5, 5, 5};
        vecs[1] = '{1, 3, 3, 3};
        vecs[2] = '{2, 1, 1, 1};
        vecs[3] = '{3, 7, 7, 7};
        vecs[4] = '{1, 0, 0, 0};
        vecs[5] = '{2, 2, 2, 2};

        resetn = 1'b0; enable = 4'b0000; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 22'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_tick", int'(tick), 0);
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_ready", int'(cfg_ready), 1);
        resetn = 1'b1;

        // Defaults on channel 0: tick every 5, square period 10.
        enable = 4'b0001;
        wait_tick(0, 40, n); check("ch0_first", n, 5);
        check("ch0_clk_high", int'(clk_out[0]), 1);
        wait_tick(0, 40, n); check("ch0_gap", n, 5);
        check("ch0_clk_low", int'(clk_out[0]), 0);

        // Retune channel 1 mid-period, then a second write queued behind it.
        enable = 4'b0011;
        step(); step();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 22'd3;
        step();
        cfg_valid = 1'b1; cfg_div = 22'd7;
        #1 check("ch1_ready_low", int'(cfg_ready), 0);
        wait_tick(1, 40, n); check("ch1_old_wrap", n, 2);
        #1 check("ch1_ready_back", int'(cfg_ready), 1);
        wait_tick(1, 40, n); check("ch1_gap3", n, 3);
        wait_tick(1, 40, n); check("ch1_gap7", n, 7);

        // Mute channel 2, then set half=1.
        enable = 4'b0111;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 22'd0;
        wait_tick(2, 40, n); check("ch2_mute_wrap", n, 5);
        wait_tick(2, 20, n); check("ch2_muted", n, 0);
        check("ch2_mute_clk", int'(clk_out[2]), 0);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 22'd1;
        wait_tick(2, 40, n); check("ch2_unmute", n, 3);
        wait_tick(2, 40, n); check("ch2_half1", n, 1);

        // Out-of-range select on the 3-channel instance always handshakes.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 22'd2;
        #1 check("oob_ready3", int'(cfg_ready3), 1);
        step();

        // Drop enable[0] while clk_out[0] is high, then restart.
        wait_tick(0, 40, n);
        if (!clk_out[0]) wait_tick(0, 40, n);
        step();
        enable[0] = 1'b0;
        step();
        check("ch0_off_clk", int'(clk_out[0]), 0);
        enable[0] = 1'b1;
        wait_tick(0, 40, n); check("ch0_restart", n, 5);

        // Vector table: program a disabled channel, enable it, measure first tick and gap.
        foreach (vecs[v]) begin
            enable = 4'b0000;
            step(); step();
            cfg_valid = 1'b1; cfg_ch = 2'(vecs[v].ch); cfg_div = 22'(vecs[v].div);
            step(); step();
            enable[vecs[v].ch] = 1'b1;
            wait_tick(vecs[v].ch, 20, n); check("vec_first", n, vecs[v].exp_first);
            wait_tick(vecs[v].ch, 20, n); check("vec_gap", n, vecs[v].exp_gap);
        end

        // Reset while a retune is pending on channel 3 (half 7).
        enable = 4'b1000;
        wait_tick(3, 40, n); check("ch3_half7", n, 7);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 22'd2;
        step(); step();
        #2 resetn = 1'b0;
        #1;
        check("async_tick", int'(tick), 0);
        check("async_clk_out", int'(clk_out), 0);
        check("async_ready", int'(cfg_ready), 1);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        wait_tick(3, 40, n); check("post_reset_first", n, 5);
        wait_tick(3, 40, n); check("post_reset_gap", n, 5);

        // Randomised traffic against the model.
        enable = 4'b1111;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(15) == 0) enable[c] = ~enable[c];
            end
            cfg_valid = ($urandom_range(3) == 0);
            cfg_ch    = 2'($urandom_range(3));
            cfg_div   = 22'($urandom_range(6));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
